// File: rtl/jericalla_seq_if.sv
// ---------------------------------------------------------------------------
// jericalla_seq_if
// Bundles the instruction handshake and the ROM/ALU/RAM lines that
// jericalla_seq owns. The slave modport is the sequencer's view. The master
// modport is the surrounding environment: instruction source, ROM, ALU, RAM.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface jericalla_seq_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8
);
   // instruction handshake
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [ADDR_W-1:0] in_dir_res;
   logic [ADDR_W-1:0] in_dir_first;
   logic [ADDR_W-1:0] in_dir_sec;
   // operand ROM
   logic [ADDR_W-1:0] rom_dir1;
   logic [ADDR_W-1:0] rom_dir2;
   logic [DATA_W-1:0] rom_data1;
   logic [DATA_W-1:0] rom_data2;
   // ALU
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [2:0]        alu_sel;
   logic [DATA_W-1:0] alu_r;
   logic              alu_zero;
   // result RAM
   logic              ram_we;
   logic [ADDR_W-1:0] ram_dir;
   logic [DATA_W-1:0] ram_din;
   // status
   logic              busy;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] result;
   logic              zero;
   logic [CNT_W-1:0]  instr_count;

   modport slave (
      input  in_valid, in_op, in_dir_res, in_dir_first, in_dir_sec,
      input  rom_data1, rom_data2, alu_r, alu_zero,
      output in_ready, rom_dir1, rom_dir2, alu_a, alu_b, alu_sel,
      output ram_we, ram_dir, ram_din,
      output busy, done, err, result, zero, instr_count
   );

   modport master (
      output in_valid, in_op, in_dir_res, in_dir_first, in_dir_sec,
      output rom_data1, rom_data2, alu_r, alu_zero,
      input  in_ready, rom_dir1, rom_dir2, alu_a, alu_b, alu_sel,
      input  ram_we, ram_dir, ram_din,
      input  busy, done, err, result, zero, instr_count
   );
endinterface

`default_nettype wire

// File: rtl/jericalla_seq.sv
// ---------------------------------------------------------------------------
// jericalla_seq
// Four-cycle instruction sequencer: IDLE -> FETCH (ROM read) -> EXEC (ALU)
// -> WRITE (RAM write). Illegal ALU selects retire from EXEC with an err
// pulse and no write. All datapath-facing outputs are registered.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module jericalla_seq #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8
) (
   input  wire             clk,
   input  wire             rst,
   jericalla_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_t;

   // highest legal ALU select; 101..111 are rejected
   localparam logic [2:0] OP_MAX = 3'b100;

   state_t            state;
   // instruction register
   logic [2:0]        op;
   logic [ADDR_W-1:0] dir_res;
   // registered outputs
   logic [ADDR_W-1:0] rom_dir1;
   logic [ADDR_W-1:0] rom_dir2;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [2:0]        alu_sel;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_dir;
   logic [DATA_W-1:0] ram_din;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] result;
   logic              zero;
   logic [CNT_W-1:0]  instr_count;

   // Sequencer FSM with registered outputs. Address/data/select lines only
   // change in the state that drives them, so they hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         op          <= '0;
         dir_res     <= '0;
         rom_dir1    <= '0;
         rom_dir2    <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_sel     <= '0;
         ram_we      <= 1'b0;
         ram_dir     <= '0;
         ram_din     <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         result      <= '0;
         zero        <= 1'b0;
         instr_count <= '0;
      end else begin
         // pulses default low; each lasts exactly one cycle
         ram_we <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;

         // count an instruction as the edge that ends its done/err pulse
         if (done || err) begin
            instr_count <= instr_count + 1'b1;
         end

         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  op       <= bus.in_op;
                  dir_res  <= bus.in_dir_res;
                  rom_dir1 <= bus.in_dir_first;
                  rom_dir2 <= bus.in_dir_sec;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               // ROM data is combinational from the addresses driven now
               alu_a   <= bus.rom_data1;
               alu_b   <= bus.rom_data2;
               alu_sel <= op;
               state   <= EXEC;
            end
            EXEC: begin
               result <= bus.alu_r;
               zero   <= bus.alu_zero;
               if (op <= OP_MAX) begin
                  ram_we  <= 1'b1;
                  ram_dir <= dir_res;
                  ram_din <= bus.alu_r;
                  done    <= 1'b1;
                  state   <= WRITE;
               end else begin
                  err   <= 1'b1;
                  state <= IDLE;
               end
            end
            WRITE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // in_ready and busy depend on state only, never on in_valid
   assign bus.in_ready    = (state == IDLE);
   assign bus.busy        = (state != IDLE);
   assign bus.rom_dir1    = rom_dir1;
   assign bus.rom_dir2    = rom_dir2;
   assign bus.alu_a       = alu_a;
   assign bus.alu_b       = alu_b;
   assign bus.alu_sel     = alu_sel;
   assign bus.ram_we      = ram_we;
   assign bus.ram_dir     = ram_dir;
   assign bus.ram_din     = ram_din;
   assign bus.done        = done;
   assign bus.err         = err;
   assign bus.result      = result;
   assign bus.zero        = zero;
   assign bus.instr_count = instr_count;

endmodule

`default_nettype wire

// File: tb/tb_jericalla_seq.sv
// ---------------------------------------------------------------------------
// tb_jericalla_seq
// Bench for jericalla_seq: models the ROM and ALU and drives instructions
// from a vector table. Expected writes and errors go into a scoreboard queue
// when an instruction is accepted, and are checked when the DUT retires it.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jericalla_seq;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int CNT_W  = 2;

   typedef struct {
      logic [2:0]        op;
      logic [ADDR_W-1:0] res;
      logic [ADDR_W-1:0] first;
      logic [ADDR_W-1:0] sec;
      logic [DATA_W-1:0] din;
      logic              zero;
   } vec_t;

   typedef struct {
      logic              legal;
      logic [ADDR_W-1:0] dir;
      logic [DATA_W-1:0] din;
      logic              zero;
      int                cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic [DATA_W-1:0] rom [16];
   exp_t              sb [$];
   logic [CNT_W-1:0]  model_cnt = '0;
   vec_t              vecs [11];

   jericalla_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   jericalla_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // reference ALU; illegal selects give 0
   function automatic logic [DATA_W-1:0] alu_f(input logic [2:0] s,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
      case (s)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         default: return '0;
      endcase
   endfunction

   assign bus.rom_data1 = rom[bus.rom_dir1];
   assign bus.rom_data2 = rom[bus.rom_dir2];
   assign bus.alu_r     = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
   assign bus.alu_zero  = (bus.alu_r == '0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // offer one instruction, push its expectation, return the handshake cycle
   task automatic send(input vec_t v, input bit keep, output int hs);
      int waited;
      exp_t e;
      waited = 0;
      hs = -1;
      bus.in_valid     = 1'b1;
      bus.in_op        = v.op;
      bus.in_dir_res   = v.res;
      bus.in_dir_first = v.first;
      bus.in_dir_sec   = v.sec;
      @(negedge clk);
      while (!(bus.in_ready && !rst)) begin
         waited++;
         if (waited > 20) begin
            fail("handshake_timeout");
            bus.in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      e.legal = (v.op <= 3'b100);
      e.dir   = v.res;
      e.din   = v.din;
      e.zero  = v.zero;
      e.cyc   = cyc + 3;
      sb.push_back(e);
      @(posedge clk);
      #1;
      hs = cyc;
      if (!keep) bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0) begin
         @(posedge clk);
         n++;
         if (n > 30) begin
            fail("drain_timeout");
            sb.delete();
            return;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      chk({tag, "_busy"},     {31'd0, bus.busy}, 32'd0);
      chk({tag, "_ram_we"},   {31'd0, bus.ram_we}, 32'd0);
      chk({tag, "_done_err"}, {30'd0, bus.done, bus.err}, 32'd0);
      chk({tag, "_result"},   bus.result, 32'd0);
      chk({tag, "_zero"},     {31'd0, bus.zero}, 32'd0);
      chk({tag, "_count"},    {30'd0, bus.instr_count}, 32'd0);
      chk({tag, "_rom_dirs"}, {24'd0, bus.rom_dir1, bus.rom_dir2}, 32'd0);
      chk({tag, "_alu_a"},    bus.alu_a, 32'd0);
      chk({tag, "_alu_b"},    bus.alu_b, 32'd0);
      chk({tag, "_alu_sel"},  {29'd0, bus.alu_sel}, 32'd0);
      chk({tag, "_ram_dir"},  {28'd0, bus.ram_dir}, 32'd0);
      chk({tag, "_ram_din"},  bus.ram_din, 32'd0);
   endtask

   // retirement monitor: pops the scoreboard on every write or err pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            model_cnt = '0;
         end else if (bus.ram_we || bus.done || bus.err) begin
            chk("done_eq_we", {31'd0, bus.done}, {31'd0, bus.ram_we});
            chk("count_before_pulse", {30'd0, bus.instr_count}, {30'd0, model_cnt});
            model_cnt = model_cnt + 1'b1;
            if (sb.size() == 0) begin
               fail("unexpected_retire");
            end else begin
               e = sb.pop_front();
               chk("retire_cycle", cyc, e.cyc);
               chk("retire_kind", {31'd0, bus.err}, {31'd0, !e.legal});
               if (e.legal) begin
                  chk("ram_dir", {28'd0, bus.ram_dir}, {28'd0, e.dir});
                  chk("ram_din", bus.ram_din, e.din);
                  chk("result", bus.result, e.din);
                  chk("zero", {31'd0, bus.zero}, {31'd0, e.zero});
                  chk("write_busy", {30'd0, bus.busy, bus.in_ready}, 32'd2);
               end else begin
                  chk("err_no_we", {31'd0, bus.ram_we}, 32'd0);
                  chk("err_in_ready", {31'd0, bus.in_ready}, 32'd1);
                  chk("err_result", bus.result, 32'd0);
                  chk("err_zero", {31'd0, bus.zero}, 32'd1);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout (t=%0t)", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int hs [3];
      int dummy;
      for (int i = 0; i < 16; i++) rom[i] = 32'h100 + i;
      rom[1] = 32'd1; rom[2] = 32'd5; rom[3] = 32'd7;
      rom[4] = 32'd6; rom[5] = 32'd6; rom[6] = 32'd8;

      //         op      res    first  sec    din            zero
      vecs[0]  = '{3'b000, 4'd9,  4'd2, 4'd3, 32'd12,        1'b0};
      vecs[1]  = '{3'b001, 4'd10, 4'd4, 4'd5, 32'd0,         1'b1};
      vecs[2]  = '{3'b100, 4'd11, 4'd1, 4'd4, 32'd1,         1'b0};
      vecs[3]  = '{3'b110, 4'd12, 4'd2, 4'd3, 32'd0,         1'b1};
      vecs[4]  = '{3'b010, 4'd13, 4'd2, 4'd3, 32'd5,         1'b0};
      vecs[5]  = '{3'b011, 4'd14, 4'd2, 4'd6, 32'd13,        1'b0};
      vecs[6]  = '{3'b001, 4'd15, 4'd2, 4'd3, 32'hFFFF_FFFE, 1'b0};
      vecs[7]  = '{3'b100, 4'd0,  4'd3, 4'd2, 32'd0,         1'b1};
      vecs[8]  = '{3'b000, 4'd2,  4'd2, 4'd2, 32'd10,        1'b0};
      vecs[9]  = '{3'b101, 4'd1,  4'd1, 4'd1, 32'd0,         1'b1};
      vecs[10] = '{3'b111, 4'd3,  4'd4, 4'd4, 32'd0,         1'b1};

      bus.in_valid = 1'b0; bus.in_op = '0;
      bus.in_dir_res = '0; bus.in_dir_first = '0; bus.in_dir_sec = '0;

      // power-on reset
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      rst = 1'b0;

      // directed table, one instruction at a time
      for (int i = 0; i < 11; i++) begin
         send(vecs[i], 1'b0, dummy);
         wait_idle();
      end
      chk("count_after_table", {30'd0, bus.instr_count}, 32'd3); // 11 mod 4

      // back-to-back with in_valid held high throughout
      send(vecs[0], 1'b1, hs[0]);
      send(vecs[4], 1'b1, hs[1]);
      send(vecs[5], 1'b0, hs[2]);
      chk("b2b_gap1", hs[1] - hs[0], 32'd4);
      chk("b2b_gap2", hs[2] - hs[1], 32'd4);
      wait_idle();
      chk("count_after_b2b", {30'd0, bus.instr_count}, 32'd2); // 14 mod 4

      // asynchronous reset mid-cycle while an instruction is in flight
      send(vecs[0], 1'b0, dummy);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_reset_outputs("async");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // counter wrap: 5 retirements from zero
      for (int i = 0; i < 5; i++) begin
         send(vecs[i], 1'b0, dummy);
         wait_idle();
      end
      chk("count_wrap", {30'd0, bus.instr_count}, 32'd1);

      // reset during WRITE: no write and no count after reset
      send(vecs[0], 1'b0, dummy);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("pre_reset_we", {31'd0, bus.ram_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("we_drops_on_reset", {31'd0, bus.ram_we}, 32'd0);
      chk("done_drops_on_reset", {31'd0, bus.done}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("count_after_write_reset", {30'd0, bus.instr_count}, 32'd0);
      chk("idle_after_write_reset", {31'd0, bus.in_ready}, 32'd1);
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
